// File: rtl/data_frm_tx_pkg.sv
// ---------------------------------------------------------------------------
// data_frm_tx_pkg
// Shared definitions for the config-byte link: frame phase codes, function
// codes, and the legality check. The decoder side uses the same codes, so a
// frame's FUNC byte and its phase numbering mean the same thing at both ends.
// ---------------------------------------------------------------------------
package data_frm_tx_pkg;

  // Byte position within a 3-byte frame; values match the decoder's state codes
  typedef enum logic [1:0] {
    STATE_FUNC = 2'd0,
    STATE_UP   = 2'd1,
    STATE_LOW  = 2'd2
  } tx_phase_e;

  localparam logic [7:0] FUNCT_NONE  = 8'h00;
  localparam logic [7:0] FUNCT_PORTA = 8'h01;
  localparam logic [7:0] FUNCT_PORTB = 8'h02;
  localparam logic [7:0] FUNCT_PORTC = 8'h03;
  localparam logic [7:0] FUNCT_PORTD = 8'h04;
  localparam logic [7:0] FUNCT_DUTYC = 8'h05;
  localparam logic [7:0] FUNCT_SCLKF = 8'h06;
  localparam logic [7:0] FUNCT_SCLKS = 8'h07;

  // FUNCT_NONE is reserved for idle filler frames, so a host may not send it
  function automatic logic isLegalFunct(input logic [7:0] funct);
    return (funct == FUNCT_PORTA) || (funct == FUNCT_PORTB) ||
           (funct == FUNCT_PORTC) || (funct == FUNCT_PORTD) ||
           (funct == FUNCT_DUTYC) || (funct == FUNCT_SCLKF) ||
           (funct == FUNCT_SCLKS);
  endfunction

endpackage

// File: rtl/data_frm_tx_cmd_fifo.sv
// ---------------------------------------------------------------------------
// data_frm_tx_cmd_fifo
// Synchronous FIFO holding queued host commands as {funct, data} words.
// Pointers carry one extra wrap bit so full and empty are told apart by the
// MSB compare. Reads are from the registered head, so a word pushed on an
// edge can only be popped from the following edge onward.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset (flushes pointers)
//   i_push           write i_pushData (ignored when full)
//   i_pushData       word to enqueue
//   i_pop            discard head word (ignored when empty)
//   o_popData        current head word, valid while !o_empty
//   o_full, o_empty  occupancy flags
// ---------------------------------------------------------------------------
module data_frm_tx_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int WIDTH = 24
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_pushData,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_popData,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic             w_doPush;
  logic             w_doPop;

  assign o_empty   = (r_wrPtr == r_rdPtr);
  assign o_full    = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                     (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_doPush  = i_push && !o_full;
  assign w_doPop   = i_pop && !o_empty;
  assign o_popData = r_mem[r_rdPtr[AW-1:0]];

  // Pointer update; simultaneous push and pop both advance, occupancy unchanged
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_ONE;
    end
  end

  // Storage needs no reset: a flushed FIFO never exposes stale words
  always_ff @(posedge i_clk) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_pushData;
  end

endmodule

// File: rtl/data_frm_tx.sv
// ---------------------------------------------------------------------------
// data_frm_tx
// Transmit side of the 8-bit config-byte link. Host commands are queued and
// sent as 3-byte frames FUNC, DATA[15:8], DATA[7:0], one byte per clock,
// locked to the decoder's free-running 3-phase cycle. With nothing queued
// a FUNCT_NONE frame with zero payload is sent, so the cycle never pauses.
// Ports:
//   i_clk, i_rst   clock shared with the decoder, sync active-high reset
//   i_cmd_valid    host command present
//   i_cmd_funct    function code
//   i_cmd_data     16-bit value for that function
//   o_cmd_ready    command accepted on an edge with valid & ready (= !full)
//   o_cmd_err      one-cycle pulse after an accepted illegal command
//   o_data_out     registered byte stream to the decoder
//   o_tx_phase     position of the byte on o_data_out (0=FUNC 1=UP 2=LOW)
//   o_tx_count     non-NONE frames started, wraps
//   o_idle         FIFO empty and the current frame is a NONE frame
// ---------------------------------------------------------------------------
module data_frm_tx
  import data_frm_tx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  input  logic [7:0]  i_cmd_funct,
  input  logic [15:0] i_cmd_data,
  output logic        o_cmd_ready,
  output logic        o_cmd_err,
  output logic [7:0]  o_data_out,
  output logic [1:0]  o_tx_phase,
  output logic [15:0] o_tx_count,
  output logic        o_idle
);

  tx_phase_e   r_phase;
  tx_phase_e   w_phaseNext;
  logic        w_load;
  logic        w_accept;
  logic        w_legal;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [23:0] w_head;
  logic [15:0] r_frame;
  logic [7:0]  r_dataOut;
  logic [15:0] r_txCount;
  logic        r_cmdErr;
  logic        r_frameNone;

  assign w_legal  = isLegalFunct(i_cmd_funct);
  assign w_accept = i_cmd_valid && o_cmd_ready;
  assign w_push   = w_accept && w_legal;
  assign w_pop    = w_load && !w_empty;

  data_frm_tx_cmd_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (24)
  ) u_cmdFifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (w_push),
    .i_pushData ({i_cmd_funct, i_cmd_data}),
    .i_pop      (w_pop),
    .o_popData  (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Phase register: free-runs with no stall so the decoder stays aligned
  always_ff @(posedge i_clk) begin
    if (i_rst) r_phase <= STATE_FUNC;
    else       r_phase <= w_phaseNext;
  end

  // Next phase; a new frame is loaded on the edge that leaves the LOW byte
  always_comb begin
    w_phaseNext = STATE_FUNC;
    w_load      = 1'b0;
    case (r_phase)
      STATE_FUNC: w_phaseNext = STATE_UP;
      STATE_UP:   w_phaseNext = STATE_LOW;
      STATE_LOW: begin
        w_phaseNext = STATE_FUNC;
        w_load      = 1'b1;
      end
      default:    w_phaseNext = STATE_FUNC;
    endcase
  end

  // Byte stream, frame payload and bookkeeping; an in-flight frame is
  // simply dropped by reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dataOut   <= FUNCT_NONE;
      r_frame     <= 16'h0000;
      r_txCount   <= 16'h0000;
      r_cmdErr    <= 1'b0;
      r_frameNone <= 1'b1;
    end else begin
      r_cmdErr <= w_accept && !w_legal;
      case (r_phase)
        STATE_LOW: begin
          if (!w_empty) begin
            r_dataOut   <= w_head[23:16];
            r_frame     <= w_head[15:0];
            r_txCount   <= r_txCount + 16'd1;
            r_frameNone <= 1'b0;
          end else begin
            r_dataOut   <= FUNCT_NONE;
            r_frame     <= 16'h0000;
            r_frameNone <= 1'b1;
          end
        end
        STATE_FUNC: r_dataOut <= r_frame[15:8];
        STATE_UP:   r_dataOut <= r_frame[7:0];
        default:    r_dataOut <= FUNCT_NONE;
      endcase
    end
  end

  assign o_cmd_ready = !w_full;
  assign o_cmd_err   = r_cmdErr;
  assign o_data_out  = r_dataOut;
  assign o_tx_phase  = r_phase;
  assign o_tx_count  = r_txCount;
  assign o_idle      = w_empty && r_frameNone;

endmodule
